decoder_stage_controller: RTL
=============================

Name: decoder_stage_controller

Overview:
- Central stage sequencer for the Helios PE array. It initiates the protocol that every processing_unit responds to.
- Drives global_stage to all PEs and consumes their aggregated busy and odd outputs.
- Iterates grow/spread/sync rounds until no odd cluster remains, then presents a result handshake to the host-side logic.
- Sits between the measurement front end and the PE array, one instance per decoder.

Parameters:
- NUM_PE, 8: number of PEs whose busy/odd outputs are observed.
- STAGE_WIDTH, 3: width of the global_stage encoding.
- SETTLE_CYCLES, 3: PE pipeline latency covered, in cycles. Covers both the quiet time in SPREAD and the sync dwell.
- MAX_ITER, 64: maximum number of grow iterations before timeout.
- ITER_WIDTH, $clog2(MAX_ITER+1): width of iteration_count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request a new decoding round; accepted when start & ready.
- ready  out  1  high only in IDLE.
- global_stage  out  STAGE_WIDTH  registered stage broadcast to all PEs.
- busy_in  in  NUM_PE  per-PE busy.
- odd_in  in  NUM_PE  per-PE odd flag.
- result_valid  out  1  high throughout RESULT.
- result_ack  in  1  consumer accepts the result; effective only when result_valid=1.
- iteration_count  out  ITER_WIDTH  grow iterations performed in the current or last round.
- timeout  out  1  last round ended with odd clusters still present.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: global_stage=IDLE, ready=1, result_valid=0, timeout=0, iteration_count=0, all internal counters 0.
- Reset mid-operation: from any state, the controller is in IDLE at the next edge with the reset values above. No residual counter state survives.
- Stage encodings (shared with the PEs): IDLE=0, MEASUREMENT_LOADING=1, GROW_BOUNDARY=2, SPREAD_CLUSTER=3, SYNC_IS_ODD=4, RESULT_VALID=5. Encodings 6-7 are never driven.
- global_stage is a register. Its value equals the current FSM state, with no combinational path from inputs.
- IDLE: ready=1. When start=1 at an edge, the next state is LOAD; iteration_count and timeout clear on the same edge.
- LOAD: lasts exactly 1 cycle, then SYNC.
- GROW: lasts exactly 1 cycle, then SPREAD. iteration_count increments by 1 on the edge entering GROW, and saturates at MAX_ITER.
- SPREAD: quiet_cnt counts consecutive cycles with busy_in==0.
  - Any busy bit set resets quiet_cnt to 0.
  - Exit to SYNC on the edge where quiet_cnt reaches SETTLE_CYCLES. Minimum dwell is SETTLE_CYCLES cycles.
  - There is no upper bound on the dwell; continuous busy keeps the controller in SPREAD.
- SYNC: dwell counter runs for exactly SETTLE_CYCLES cycles. |odd_in is sampled on the final cycle only.
  - odd=0 -> RESULT, timeout=0.
  - odd=1 and iteration_count<MAX_ITER -> GROW.
  - odd=1 and iteration_count==MAX_ITER -> RESULT with timeout=1.
- RESULT: result_valid=1; iteration_count and timeout are held stable.
  - result_ack=1 -> IDLE on the next edge.
  - Holds indefinitely without ack.
- Handshake edge cases:
  - start outside IDLE is ignored and not queued.
  - result_ack outside RESULT is ignored.
  - start and result_ack in the same RESULT cycle: go to IDLE only. The start is not captured.
- Counter widths: quiet_cnt and the dwell counter are $clog2(SETTLE_CYCLES+1) bits and never wrap.
- Latency, no-defect round: start accepted at edge E0. global_stage=LOAD after E0, SYNC after E1, RESULT after E4 (SETTLE_CYCLES=3). result_valid rises 5 edges after acceptance.

Test Plan:
- No defects: odd_in=0, busy_in=0, pulse start -> stage sequence LOAD, SYNC×3, RESULT. result_valid=1 at the 5th edge, iteration_count=0, timeout=0. Ack -> IDLE, ready=1.
- One iteration: odd_in[0]=1 until the first GROW, then 0. busy_in[3]=1 for the first 2 SPREAD cycles -> sequence LOAD, SYNC×3, GROW, SPREAD×5, SYNC×3, RESULT. iteration_count=1, timeout=0.
- Busy glitch restarts quiet: in SPREAD, busy_in pattern 0,0,1,0,0,0 -> SYNC entered only after the final 3 zeros. Total SPREAD dwell is 6 cycles.
- Timeout: MAX_ITER=4, odd_in[7]=1 held -> 4 GROW entries, then RESULT with iteration_count=4, timeout=1. iteration_count is stable until ack.
- Handshake abuse: start pulsed during SPREAD and during RESULT, result_ack pulsed during SPREAD -> no state change from either. In RESULT, start+ack together -> IDLE, and no new round begins.
- Reset mid-SPREAD with busy_in high: assert reset for 1 cycle -> next edge global_stage=0, ready=1, result_valid=0, iteration_count=0, timeout=0. A subsequent start runs a clean no-defect round (5 edges).

Source files
------------

// File: rtl/decoder_stage_controller.sv
// Stage sequencer for the PE array: broadcasts global_stage and iterates
// grow/spread/sync rounds until no odd cluster remains or MAX_ITER is hit.
module decoder_stage_controller #(
    parameter int NUM_PE        = 8,
    parameter int STAGE_WIDTH   = 3,
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_ITER      = 64,
    parameter int ITER_WIDTH    = $clog2(MAX_ITER + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    output logic [STAGE_WIDTH-1:0] global_stage,
    input  logic [NUM_PE-1:0]      busy_in,
    input  logic [NUM_PE-1:0]      odd_in,
    output logic                   result_valid,
    input  logic                   result_ack,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_MAX = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_GROW   = 3'd2,
        S_SPREAD = 3'd3,
        S_SYNC   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [CW-1:0]         quiet_cnt;
    logic [CW-1:0]         quiet_nx;
    logic [CW-1:0]         dwell_cnt;
    logic [CW-1:0]         dwell_nx;
    logic [ITER_WIDTH-1:0] iter_nx;
    logic                  timeout_nx;
    logic                  any_busy;
    logic                  any_odd;

    assign any_busy = |busy_in;
    assign any_odd  = |odd_in;

    // The state register itself is the broadcast, so no input reaches it
    // combinationally.
    assign global_stage = STAGE_WIDTH'(state);
    assign ready        = (state == S_IDLE);
    assign result_valid = (state == S_RESULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            quiet_cnt       <= '0;
            dwell_cnt       <= '0;
            iteration_count <= '0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nx;
            quiet_cnt       <= quiet_nx;
            dwell_cnt       <= dwell_nx;
            iteration_count <= iter_nx;
            timeout         <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        quiet_nx   = quiet_cnt;
        dwell_nx   = dwell_cnt;
        iter_nx    = iteration_count;
        timeout_nx = timeout;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_LOAD;
                    iter_nx    = '0;
                    timeout_nx = 1'b0;
                end
            end
            S_LOAD: begin
                state_nx = S_SYNC;
                dwell_nx = '0;
            end
            S_GROW: begin
                state_nx = S_SPREAD;
                quiet_nx = '0;
            end
            S_SPREAD: begin
                // Any busy PE restarts the quiet window.
                if (any_busy) begin
                    quiet_nx = '0;
                end else begin
                    quiet_nx = quiet_cnt + 1'b1;
                    if (quiet_cnt == SETTLE_LAST) begin
                        state_nx = S_SYNC;
                        dwell_nx = '0;
                    end
                end
            end
            S_SYNC: begin
                dwell_nx = dwell_cnt + 1'b1;
                if (dwell_cnt == SETTLE_LAST) begin
                    if (!any_odd) begin
                        state_nx   = S_RESULT;
                        timeout_nx = 1'b0;
                    end else if (iteration_count < ITER_MAX) begin
                        state_nx = S_GROW;
                        iter_nx  = iteration_count + 1'b1;
                    end else begin
                        state_nx   = S_RESULT;
                        timeout_nx = 1'b1;
                    end
                end
            end
            S_RESULT: begin
                if (result_ack) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
